bank_rw_server: RTL

- Per-bank service engine at the far end of the bank request FIFOs. It pops row-write entries from the bank's wFIFO and row-read requests from the bank's rFIFO, and performs them on a single-port scratchpad bank SRAM.
- Read data is routed by target type:
  - mat_t=0 (store) goes to the store response port, tagged with the store address.
  - mat_t=1/2/3 (input/weight/partial sum) goes to the systolic-array operand port.
- One instance sits beside each bank's access FSM; the FSM fills the FIFOs and this block drains them.

---
 rtl/bank_rw_server.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bank_rw_server.sv
// Per-bank service engine: drains the write-entry and read-request FIFOs of
// one scratchpad bank into its single-port SRAM and routes read data either
// to the store response port (mat_t=0) or to the systolic-array operand port.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no read in flight; a read may be issued, writes drain freely
// RD_WAIT | read issued last cycle; SRAM data is captured this cycle
// RESP    | response held on store_* or gemm_* until the matching ready
module bank_rw_server #(
    parameter int BANK_NUM     = 0,
    parameter int MAT_S_W      = 4,
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 32,
    parameter int WR_BURST_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    // write-entry FIFO (first-word-fall-through)
    input  logic                 wFIFO_empty,
    input  logic                 wFIFO_rdata_gemm_result,
    input  logic [MAT_S_W-1:0]   wFIFO_rdata_mat_s,
    input  logic [1:0]           wFIFO_rdata_row_s,
    input  logic [DATA_W-1:0]    wFIFO_rdata_data,
    output logic                 wFIFO_REN,
    // read-request FIFO (first-word-fall-through)
    input  logic                 rFIFO_empty,
    input  logic [ADDR_W-1:0]    rFIFO_rdata_addr,
    input  logic [1:0]           rFIFO_rdata_mat_t,
    input  logic [MAT_S_W-1:0]   rFIFO_rdata_mat_s,
    input  logic [1:0]           rFIFO_rdata_row_s,
    output logic                 rFIFO_REN,
    // bank SRAM port
    output logic                 sram_ren,
    output logic                 sram_wen,
    output logic [MAT_S_W+1:0]   sram_addr,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata,
    // store response
    output logic                 store_valid,
    input  logic                 store_ready,
    output logic [ADDR_W-1:0]    store_addr,
    output logic [1:0]           store_row,
    output logic [DATA_W-1:0]    store_data,
    // systolic-array operand
    output logic                 gemm_valid,
    input  logic                 gemm_ready,
    output logic [1:0]           gemm_type,
    output logic [1:0]           gemm_row,
    output logic [DATA_W-1:0]    gemm_data,
    output logic [15:0]          gemm_wr_count
);

    // Counter is wide enough to hold WR_BURST_MAX itself, and at least 1 bit.
    localparam int BC_W = $clog2(WR_BURST_MAX + 2);
    localparam logic [BC_W-1:0] BURST_LIM = BC_W'(WR_BURST_MAX);
    localparam logic [1:0]      MAT_STORE = 2'd0;

    // BANK_NUM identifies the instance only; no port of this block carries it.
    if (BANK_NUM < 0) begin : g_bank_num_negative
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    state_t              state_q, state_d;

    // tag of the read currently in flight
    logic [1:0]          tag_mat_t_q, tag_mat_t_d;
    logic [ADDR_W-1:0]   tag_addr_q,  tag_addr_d;
    logic [1:0]          tag_row_q,   tag_row_d;

    // held response
    logic [1:0]          resp_mat_t_q, resp_mat_t_d;
    logic [ADDR_W-1:0]   resp_addr_q,  resp_addr_d;
    logic [1:0]          resp_row_q,   resp_row_d;
    logic [DATA_W-1:0]   resp_data_q,  resp_data_d;

    logic [BC_W-1:0]     burst_q, burst_d;
    logic [15:0]         gemm_cnt_q, gemm_cnt_d;

    logic                resp_hs;
    logic                rd_grant;
    logic                wr_grant;

    // Next-state, port arbitration and SRAM/FIFO strobes.
    always_comb begin
        state_d      = state_q;
        tag_mat_t_d  = tag_mat_t_q;
        tag_addr_d   = tag_addr_q;
        tag_row_d    = tag_row_q;
        resp_mat_t_d = resp_mat_t_q;
        resp_addr_d  = resp_addr_q;
        resp_row_d   = resp_row_q;
        resp_data_d  = resp_data_q;
        burst_d      = burst_q;
        gemm_cnt_d   = gemm_cnt_q;
        resp_hs      = 1'b0;
        rd_grant     = 1'b0;
        wr_grant     = 1'b0;
        wFIFO_REN    = 1'b0;
        rFIFO_REN    = 1'b0;
        sram_ren     = 1'b0;
        sram_wen     = 1'b0;
        sram_addr    = '0;
        sram_wdata   = '0;
        store_valid  = 1'b0;
        gemm_valid   = 1'b0;

        if (state_q == ST_RESP) begin
            if (resp_mat_t_q == MAT_STORE) begin
                store_valid = 1'b1;
                resp_hs     = store_ready;
            end else begin
                gemm_valid  = 1'b1;
                resp_hs     = gemm_ready;
            end
        end

        // A read may only take the port when the response path is free; a
        // pending write keeps priority until the burst limit is reached.
        rd_grant = ((state_q == ST_IDLE) || resp_hs) && !rFIFO_empty &&
                   (wFIFO_empty || (burst_q >= BURST_LIM));
        wr_grant = !wFIFO_empty && !rd_grant;

        if (rd_grant) begin
            rFIFO_REN   = 1'b1;
            sram_ren    = 1'b1;
            sram_addr   = {rFIFO_rdata_mat_s, rFIFO_rdata_row_s};
            tag_mat_t_d = rFIFO_rdata_mat_t;
            tag_addr_d  = rFIFO_rdata_addr;
            tag_row_d   = rFIFO_rdata_row_s;
        end else if (wr_grant) begin
            wFIFO_REN   = 1'b1;
            sram_wen    = 1'b1;
            sram_addr   = {wFIFO_rdata_mat_s, wFIFO_rdata_row_s};
            sram_wdata  = wFIFO_rdata_data;
            if (wFIFO_rdata_gemm_result) begin
                gemm_cnt_d = gemm_cnt_q + 16'd1;
            end
        end

        // Saturating: during a long downstream stall writes keep draining.
        if (rd_grant || rFIFO_empty) begin
            burst_d = '0;
        end else if (wr_grant && (burst_q < BURST_LIM)) begin
            burst_d = burst_q + BC_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_grant) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                resp_mat_t_d = tag_mat_t_q;
                resp_addr_d  = tag_addr_q;
                resp_row_d   = tag_row_q;
                resp_data_d  = sram_rdata;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_hs) begin
                    state_d = rd_grant ? ST_RD_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, tag, response and counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            tag_mat_t_q  <= '0;
            tag_addr_q   <= '0;
            tag_row_q    <= '0;
            resp_mat_t_q <= '0;
            resp_addr_q  <= '0;
            resp_row_q   <= '0;
            resp_data_q  <= '0;
            burst_q      <= '0;
            gemm_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tag_mat_t_q  <= tag_mat_t_d;
            tag_addr_q   <= tag_addr_d;
            tag_row_q    <= tag_row_d;
            resp_mat_t_q <= resp_mat_t_d;
            resp_addr_q  <= resp_addr_d;
            resp_row_q   <= resp_row_d;
            resp_data_q  <= resp_data_d;
            burst_q      <= burst_d;
            gemm_cnt_q   <= gemm_cnt_d;
        end
    end

    assign store_addr    = resp_addr_q;
    assign store_row     = resp_row_q;
    assign store_data    = resp_data_q;
    assign gemm_type     = resp_mat_t_q;
    assign gemm_row      = resp_row_q;
    assign gemm_data     = resp_data_q;
    assign gemm_wr_count = gemm_cnt_q;

endmodule
